// File: rtl/act_skew_feeder.sv
// Activation feeder: streams a tile of 128-bit activation words from SRAM and applies the
// triangular row skew for the systolic array. Optional bubble counter: define ACT_BUBBLE_CNT_EN.
module act_skew_feeder #(
  parameter int ROWS = 32,
  parameter int AW   = 15,
  parameter int NW   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [AW-1:0]       base_addr,
  input  logic [NW-1:0]       num_vec,
  output logic                busy,
  output logic                done,
  output logic                bce,
  output logic [AW-1:0]       braddr,
  input  logic                brvalid,
  input  logic [4*ROWS-1:0]   brdata,
  output logic [4*ROWS-1:0]   act_data_in,
  output logic                act_pe_valid,
`ifdef ACT_BUBBLE_CNT_EN
  output logic [15:0]         bubble_cnt,
`endif
  output logic                start_calc
);

  localparam int DW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [NW-1:0]     nv_q;
  logic [NW-1:0]     issue_cnt;
  logic [NW-1:0]     rcv_cnt;
  logic [NW-1:0]     rcv_next;
  logic [DW-1:0]     drain_cnt;
  logic [4*ROWS-1:0] stage0;
  logic              beat;

  // Only beats that arrive while the job expects data are counted and injected.
  assign beat = brvalid && (state == S_READ || state == S_WAIT);

  always_comb begin
    // NOTE: assign a default before any conditional update so no latch is inferred.
    rcv_next = rcv_cnt;
    if (beat) rcv_next = rcv_cnt + NW'(1);
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      nv_q       <= '0;
      issue_cnt  <= '0;
      rcv_cnt    <= '0;
      drain_cnt  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bce        <= 1'b0;
      braddr     <= '0;
      start_calc <= 1'b0;
    end else begin
      done       <= 1'b0;
      start_calc <= 1'b0;
      if (beat) rcv_cnt <= rcv_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            nv_q    <= num_vec;
            rcv_cnt <= '0;
            busy    <= 1'b1;
            if (num_vec == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state      <= S_READ;
              bce        <= 1'b1;
              braddr     <= base_addr;
              issue_cnt  <= NW'(1);
              start_calc <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (issue_cnt == nv_q) begin
            bce   <= 1'b0;
            state <= S_WAIT;
          end else begin
            issue_cnt <= issue_cnt + NW'(1);
            braddr    <= braddr + AW'(1);
          end
        end
        S_WAIT: begin
          if (rcv_next == nv_q) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end
        end
        S_DRAIN: begin
          // Hold off done until the last vector has walked down to the bottom row.
          if (drain_cnt == DW'(ROWS - 1)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ACT_BUBBLE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      bubble_cnt <= '0;
    end else if ((state == S_READ || state == S_WAIT) && !brvalid && rcv_cnt != '0
                 && bubble_cnt != 16'hFFFF) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

  // Stage 0 loads every cycle; a missing beat becomes a zero column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage0       <= '0;
      act_pe_valid <= 1'b0;
    end else begin
      stage0       <= beat ? brdata : '0;
      act_pe_valid <= beat;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    if (r == 0) begin : g_direct
      assign act_data_in[3:0] = stage0[3:0];
    end else begin : g_chain
      logic [3:0] dly [r];
      // NOTE: the skew chains are reset so an aborted job cannot leak stale columns into the core.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < r; k++) dly[k] <= '0;
        end else begin
          dly[0] <= stage0[4*r +: 4];
          for (int k = 1; k < r; k++) dly[k] <= dly[k-1];
        end
      end
      assign act_data_in[4*r +: 4] = dly[r-1];
    end
  end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Randomised bench for act_skew_feeder: a variable-latency SRAM responder plus a timeline model
// that predicts every output each cycle from the job start, beat history and the skew rule.
module tb_act_skew_feeder;
  localparam int ROWS       = 32;
  localparam int AW         = 15;
  localparam int NW         = 16;
  localparam int DWID       = 4 * ROWS;
  localparam int JOB_BUDGET = 400;
  localparam int M_ROWID    = 0;
  localparam int M_INDEX    = 1;
  localparam int M_RAND     = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [NW-1:0]   num_vec = '0;
  logic            busy, done, bce;
  logic [AW-1:0]   braddr;
  logic            brvalid = 1'b0;
  logic [DWID-1:0] brdata = '0;
  logic [DWID-1:0] act_data_in;
  logic            act_pe_valid;
  logic            start_calc;
`ifdef ACT_BUBBLE_CNT_EN
  logic [15:0]     bubble_cnt;
`endif

  act_skew_feeder #(.ROWS(ROWS), .AW(AW), .NW(NW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .num_vec      (num_vec),
    .busy         (busy),
    .done         (done),
    .bce          (bce),
    .braddr       (braddr),
    .brvalid      (brvalid),
    .brdata       (brdata),
    .act_data_in  (act_data_in),
    .act_pe_valid (act_pe_valid),
`ifdef ACT_BUBBLE_CNT_EN
    .bubble_cnt   (bubble_cnt),
`endif
    .start_calc   (start_calc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int hist_lo = 0;

  // Beat history (ring; only the last ROWS+1 cycles matter).
  bit              cnt_v [64];
  logic [DWID-1:0] cnt_d [64];

  // Current job timeline.
  bit            job_on = 1'b0;
  int            js, jn, beats, issued, bce_seen, bub;
  int            jl = -1;
  int            jd = -1;
  logic [AW-1:0] jbase;

  typedef struct {
    int              due;
    logic [DWID-1:0] data;
  } rd_t;
  rd_t q[$];
  int  last_due;

  int            lat_lo = 1, lat_hi = 1, mode = M_ROWID, gap_after = -1, gap_left = 0;
  bit            spur = 1'b0;
  bit            start_req = 1'b0;
  logic [AW-1:0] req_base = '0;
  logic [NW-1:0] req_n = '0;

  task automatic check(input string tag, input logic [DWID-1:0] got, input logic [DWID-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit model_idle(int c);
    return !job_on || (jd >= 0 && c > jd);
  endfunction

  function automatic bit in_window();
    return job_on && cyc >= js + 1 && jl < 0;
  endfunction

  function automatic logic [DWID-1:0] rand_word();
    logic [DWID-1:0] w;
    for (int i = 0; i < DWID / 32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [DWID-1:0] make_word(int k);
    logic [DWID-1:0] w;
    w = '0;
    if (mode == M_ROWID) begin
      for (int r = 0; r < ROWS; r++) w[4*r +: 4] = 4'(r);
    end else if (mode == M_INDEX) begin
      for (int r = 0; r < ROWS; r++) w[4*r +: 4] = 4'(k);
    end else begin
      w = rand_word();
    end
    return w;
  endfunction

  task automatic check_outputs();
    logic [DWID-1:0] e_act;
    logic [AW-1:0]   e_addr;
    bit              e_bce, e_pv;
    int              idx;
    e_act = '0;
    for (int r = 0; r < ROWS; r++) begin
      idx = cyc - 1 - r;
      if (idx >= hist_lo && idx >= 0 && cnt_v[6'(idx)]) e_act[4*r +: 4] = cnt_d[6'(idx)][4*r +: 4];
    end
    e_pv = (cyc >= 1 && cyc - 1 >= hist_lo) ? cnt_v[6'(cyc - 1)] : 1'b0;
    e_bce = job_on && cyc >= js + 1 && cyc <= js + jn;
    check("act_data", act_data_in, e_act);
    check("act_pe_valid", DWID'(act_pe_valid), DWID'(e_pv));
    check("bce", DWID'(bce), DWID'(e_bce));
    if (e_bce) begin
      e_addr = jbase + AW'(cyc - js - 1);
      check("braddr", DWID'(braddr), DWID'(e_addr));
    end
    check("start_calc", DWID'(start_calc), DWID'(job_on && jn > 0 && cyc == js + 1));
    check("done", DWID'(done), DWID'(job_on && jd >= 0 && cyc == jd));
    check("busy", DWID'(busy), DWID'(job_on && cyc >= js + 1 && (jd < 0 || cyc <= jd)));
`ifdef ACT_BUBBLE_CNT_EN
    check("bubble_cnt", DWID'(bubble_cnt), DWID'(bub));
`endif
  endtask

  // One clock: sample and compare outputs, then act as SRAM and drive the next inputs.
  task automatic step();
    rd_t rd;
    bit  pop, counted;
    int  due;
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    brvalid = 1'b0;
    brdata  = rand_word();
    pop = (q.size() > 0) && (q[0].due <= cyc);
    if (pop && beats == gap_after && gap_left > 0) begin
      pop = 1'b0;
      gap_left--;
    end
    if (pop) begin
      rd = q.pop_front();
      brvalid = 1'b1;
      brdata  = rd.data;
    end else if (spur && q.size() == 0 && !in_window() && $urandom_range(3, 0) == 0) begin
      brvalid = 1'b1;
    end
    if (bce) begin
      due = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (due <= last_due) due = last_due + 1;
      q.push_back('{due: due, data: make_word(issued)});
      last_due = due;
      issued++;
      bce_seen++;
    end
    start     = start_req;
    base_addr = req_base;
    num_vec   = req_n;
    if (start_req && model_idle(cyc)) begin
      job_on   = 1'b1;
      js       = cyc;
      jn       = int'(req_n);
      jbase    = req_base;
      jl       = -1;
      jd       = (jn == 0) ? cyc + 1 : -1;
      beats    = 0;
      bub      = 0;
      issued   = 0;
      bce_seen = 0;
      last_due = cyc;
    end
    counted = brvalid && in_window();
    if (in_window() && !brvalid && beats > 0 && bub < 65535) bub++;
    cnt_v[6'(cyc)] = counted;
    cnt_d[6'(cyc)] = brdata;
    if (counted) begin
      beats++;
      if (beats == jn) begin
        jl = cyc;
        jd = cyc + ROWS + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic reset_mid_job();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_act_data", act_data_in, '0);
    check("rst_act_pe_valid", DWID'(act_pe_valid), '0);
    check("rst_bce", DWID'(bce), '0);
    check("rst_braddr", DWID'(braddr), '0);
    check("rst_busy", DWID'(busy), '0);
    check("rst_done", DWID'(done), '0);
    check("rst_start_calc", DWID'(start_calc), '0);
`ifdef ACT_BUBBLE_CNT_EN
    check("rst_bubble_cnt", DWID'(bubble_cnt), '0);
`endif
    job_on    = 1'b0;
    q.delete();
    bub       = 0;
    hist_lo   = cyc + 1;
    start     = 1'b0;
    start_req = 1'b0;
    brvalid   = 1'b0;
    gap_left  = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
      cnt_v[6'(cyc)] = 1'b0;
      check_outputs();
    end
    rst_n = 1'b1;
  endtask

  task automatic run_job(input logic [AW-1:0] b, input int n, input int llo, input int lhi,
                         input int md, input int gafter, input int glen, input bit mids,
                         input bit abort);
    int budget;
    lat_lo    = llo;
    lat_hi    = lhi;
    mode      = md;
    gap_after = gafter;
    gap_left  = glen;
    start_req = 1'b1;
    req_base  = b;
    req_n     = NW'(n);
    step();
    start_req = 1'b0;
    budget = 0;
    while (!(jd >= 0 && cyc >= jd) && budget < JOB_BUDGET) begin
      if (abort && jl >= 0 && cyc >= jl + 10) break;
      if (mids && $urandom_range(2, 0) == 0) begin
        start_req = 1'b1;
        req_base  = AW'($urandom);
        req_n     = NW'($urandom_range(20, 1));
      end
      step();
      start_req = 1'b0;
      budget++;
    end
    check("job_in_budget", DWID'(budget < JOB_BUDGET), DWID'(1));
    check("read_count", DWID'(bce_seen), DWID'(n));
    if (abort) reset_mid_job();
    if (budget >= JOB_BUDGET) job_on = 1'b0;
  endtask

  initial begin
    int n, lh, ga;
    for (int i = 0; i < 64; i++) cnt_v[i] = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      cyc++;
      check_outputs();
      check("reset_braddr", DWID'(braddr), '0);
    end
    rst_n = 1'b1;
    idle(2);

    // Single vector, latency 1, row r nibble = r.
    run_job(15'h010, 1, 1, 1, M_ROWID, -1, 0, 1'b0, 1'b0);
    idle(3);
    // Streaming eight words, latency 2, word k all nibbles = k.
    run_job(AW'($urandom), 8, 2, 2, M_INDEX, -1, 0, 1'b0, 1'b0);
    // Three-cycle gap after the second beat.
    run_job(AW'($urandom), 4, 1, 1, M_RAND, 2, 3, 1'b0, 1'b0);
`ifdef ACT_BUBBLE_CNT_EN
    check("gap_bubble", DWID'(bubble_cnt), DWID'(3));
`endif
    // Address wrap at the top of the SRAM.
    run_job(15'h7FFE, 4, 1, 3, M_RAND, -1, 0, 1'b0, 1'b0);
    spur = 1'b1;
    // Start pulses while busy are ignored.
    run_job(AW'($urandom), 10, 1, 4, M_RAND, -1, 0, 1'b1, 1'b0);
    // Empty job, immediately followed by a back-to-back job.
    run_job(AW'($urandom), 0, 1, 1, M_RAND, -1, 0, 1'b0, 1'b0);
    run_job(AW'($urandom), 3, 1, 2, M_RAND, -1, 0, 1'b0, 1'b0);
    // Reset in the middle of the drain, then a normal job.
    run_job(AW'($urandom), 5, 1, 2, M_RAND, -1, 0, 1'b0, 1'b1);
    run_job(AW'($urandom), 6, 1, 3, M_RAND, -1, 0, 1'b0, 1'b0);

    for (int j = 0; j < 20; j++) begin
      n  = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(24, 1));
      lh = int'($urandom_range(5, 1));
      ga = ($urandom_range(1, 0) == 1) ? int'($urandom_range(n, 0)) : -1;
      run_job(AW'($urandom), n, 1, lh, M_RAND, ga, int'($urandom_range(4, 1)),
              $urandom_range(3, 0) == 0, 1'b0);
      if ($urandom_range(1, 0) == 1) idle(int'($urandom_range(3, 1)));
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
